fifo_lvl: RTL
=============

FIFO_LVL -- requirements
Module: fifo_lvl

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: bits per data element.
REQ-002 SHALL have parameter BITDEPTH, default 4: capacity is 2**BITDEPTH elements (full capacity, no slot wasted).
REQ-003 SHALL have parameter AFULL_LVL, default 2**BITDEPTH-2: almost-full threshold, in elements.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2: almost-empty threshold, in elements.
REQ-005 SHALL have port clk6x, input, 1: the single clock, 48MHz; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-007 SHALL have port flush_i, input, 1: discard all contents.
REQ-008 SHALL have port wport_i, input, BITWIDTH: write data.
REQ-009 SHALL have port wenq_i, input, 1: enqueue request.
REQ-010 SHALL have port rport_o, output, BITWIDTH: head element; valid while empty_o=0.
REQ-011 SHALL have port rdeq_i, input, 1: dequeue request.
REQ-012 SHALL have port full_o, output, 1: level equals 2**BITDEPTH.
REQ-013 SHALL have port empty_o, output, 1: level equals 0.
REQ-014 SHALL have port afull_o, output, 1: level >= AFULL_LVL.
REQ-015 SHALL have port aempty_o, output, 1: level <= AEMPTY_LVL.
REQ-016 SHALL have port level_o, output, BITDEPTH+1: current element count.
REQ-017 SHALL have port err_clr_i, input, 1: clear sticky error flags.
REQ-018 SHALL have port ovf_o, output, 1: sticky overflow flag.
REQ-019 SHALL have port unf_o, output, 1: sticky underflow flag.

Function
REQ-020 SHALL accept a dequeue iff rdeq_i=1 and empty_o=0; an accepted dequeue advances the read pointer.
REQ-021 SHALL accept an enqueue iff wenq_i=1 and (full_o=0 or a dequeue is accepted in the same cycle); an accepted enqueue writes mem[wptr] and advances the write pointer.
REQ-022 SHALL update level: +1 for enqueue only, -1 for dequeue only, unchanged for both or neither.
REQ-023 SHALL register all status outputs (full_o, empty_o, afull_o, aempty_o, level_o) from the next-state level, so they are valid in the cycle after the access.
REQ-024 SHALL drive rport_o combinationally from mem[rptr] (first-word fall-through); an element is visible on the edge after it is enqueued.
REQ-025 SHALL wrap pointers modulo 2**BITDEPTH.
REQ-026 SHALL, on flush_i=1, reset pointers and level to 0, set empty_o=1, and ignore wenq_i and rdeq_i in that cycle; memory contents are left unchanged.
REQ-027 SHALL, with enqueue and dequeue both accepted while empty_o=0, return the old head on rport_o that cycle.
REQ-028 SHALL treat a rejected enqueue as an overflow event and a rejected dequeue as an underflow event; the FIFO state is left unchanged.

Reset
REQ-029 SHALL, on reset=1, set rptr=0, wptr=0, level_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, ovf_o=0, unf_o=0; reset overrides flush and all requests.
REQ-030 SHALL, on reset mid-operation, discard all contents; rport_o is undefined until the next enqueue.

Configuration
REQ-031 SHALL, with macro FIFO_LVL_STICKY_ERR_EN defined, set ovf_o/unf_o on the edge after the event and hold them until err_clr_i=1 or reset; on err_clr_i with a simultaneous event, the event wins and the flag stays 1.
REQ-032 SHALL, without FIFO_LVL_STICKY_ERR_EN, keep all ports present, tie ovf_o=0 and unf_o=0, and ignore err_clr_i.

Structure
REQ-033 SHALL place the level-width constant/function and the default-threshold constants in shared package fifo_pkg.
REQ-034 SHALL implement storage as sub-module fifo_lvl_mem: 2**BITDEPTH x BITWIDTH array, one synchronous write port, one asynchronous read port.

Verification
REQ-035 SHALL cover: fill 16 words (BITDEPTH=4) -> full_o=1, level_o=16, afull_o=1 from level 14; drain -> values in order, empty_o=1.
REQ-036 SHALL cover: full plus simultaneous wenq/rdeq -> both accepted, level_o stays 16, no overflow.
REQ-037 SHALL cover: wenq at full without rdeq -> write rejected, ovf_o=1 (macro on) / 0 (macro off); err_clr_i -> ovf_o=0.
REQ-038 SHALL cover: rdeq at empty -> unf_o=1, level_o=0, pointers unchanged.
REQ-039 SHALL cover: 5 words in, then flush_i with wenq_i=1 -> level_o=0, empty_o=1 next cycle, write dropped.
REQ-040 SHALL cover: 40 random mixed accesses spanning pointer wrap -> output order matches a reference model, level_o exact every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_lvl family: level width helper, default
// thresholds and the per-cycle access decode record.
package fifo_pkg;

  localparam int DEF_BITWIDTH   = 8;
  localparam int DEF_BITDEPTH   = 4;
  localparam int DEF_AEMPTY_LVL = 2;

  // One extra bit so a completely full FIFO (2**bitdepth) is representable.
  function automatic int lvl_width(input int bitdepth);
    return bitdepth + 1;
  endfunction

  function automatic int def_afull_lvl(input int bitdepth);
    return (2 ** bitdepth) - 2;
  endfunction

  typedef struct packed {
    logic enq;
    logic deq;
    logic ovf;
    logic unf;
  } acc_t;

endpackage

// File: rtl/fifo_lvl_mem.sv
// Storage array for fifo_lvl: one synchronous write port, one asynchronous
// read port; no reset, contents persist across flush.
module fifo_lvl_mem
  import fifo_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int BITDEPTH = DEF_BITDEPTH
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [BITDEPTH-1:0] i_waddr,
  input  logic [BITWIDTH-1:0] i_wdat,
  input  logic [BITDEPTH-1:0] i_raddr,
  output logic [BITWIDTH-1:0] o_rdat
);

  logic [BITWIDTH-1:0] r_mem [2**BITDEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Fall-through FIFO with registered level/threshold flags (valid the cycle after an access);
// a full FIFO still takes a write paired with a read. Sticky ovf/unf flags need FIFO_LVL_STICKY_ERR_EN.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int BITWIDTH   = DEF_BITWIDTH,
  parameter int BITDEPTH   = DEF_BITDEPTH,
  parameter int AFULL_LVL  = def_afull_lvl(BITDEPTH),
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic                clk6x,
  input  logic                reset,
  input  logic                flush_i,
  input  logic [BITWIDTH-1:0] wport_i,
  input  logic                wenq_i,
  output logic [BITWIDTH-1:0] rport_o,
  input  logic                rdeq_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                afull_o,
  output logic                aempty_o,
  output logic [BITDEPTH:0]   level_o,
  input  logic                err_clr_i,
  output logic                ovf_o,
  output logic                unf_o
);

  localparam int            LW        = lvl_width(BITDEPTH);
  localparam int            CAP_I     = 2 ** BITDEPTH;
  localparam logic [LW-1:0] CAP       = LW'(CAP_I);
  localparam logic [LW-1:0] AFULL_TH  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] AEMPTY_TH = LW'(AEMPTY_LVL);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [BITDEPTH-1:0] PTR_ONE = BITDEPTH'(1);

  logic [BITDEPTH-1:0] r_rptr;
  logic [BITDEPTH-1:0] r_wptr;
  logic [BITDEPTH-1:0] w_rptr_nxt;
  logic [BITDEPTH-1:0] w_wptr_nxt;
  logic [LW-1:0]       r_level;
  logic [LW-1:0]       w_level_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                w_we;
  acc_t                w_acc;

  // A write into a full FIFO is legal only when a read frees the head slot in the same cycle.
  always_comb begin
    w_acc     = '0;
    w_acc.deq = rdeq_i & ~r_empty & ~flush_i;
    w_acc.enq = wenq_i & (~r_full | w_acc.deq) & ~flush_i;
    w_acc.ovf = wenq_i & ~w_acc.enq & ~flush_i;
    w_acc.unf = rdeq_i & r_empty & ~flush_i;
  end

  always_comb begin
    w_rptr_nxt  = r_rptr;
    w_wptr_nxt  = r_wptr;
    w_level_nxt = r_level;
    if (flush_i) begin
      w_rptr_nxt  = '0;
      w_wptr_nxt  = '0;
      w_level_nxt = '0;
    end else begin
      if (w_acc.deq) begin
        w_rptr_nxt = r_rptr + PTR_ONE;
      end
      if (w_acc.enq) begin
        w_wptr_nxt = r_wptr + PTR_ONE;
      end
      case ({w_acc.enq, w_acc.deq})
        2'b10:   w_level_nxt = r_level + LVL_ONE;
        2'b01:   w_level_nxt = r_level - LVL_ONE;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_rptr   <= w_rptr_nxt;
      r_wptr   <= w_wptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == CAP);
      r_empty  <= (w_level_nxt == '0);
      r_afull  <= (w_level_nxt >= AFULL_TH);
      r_aempty <= (w_level_nxt <= AEMPTY_TH);
    end
  end

  assign w_we = w_acc.enq & ~reset;

  fifo_lvl_mem #(
    .BITWIDTH (BITWIDTH),
    .BITDEPTH (BITDEPTH)
  ) u_mem (
    .i_clk   (clk6x),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdat  (wport_i),
    .i_raddr (r_rptr),
    .o_rdat  (rport_o)
  );

`ifdef FIFO_LVL_STICKY_ERR_EN
  logic r_ovf;
  logic r_unf;

  // A new event beats a simultaneous clear so no error is ever lost.
  always_ff @(posedge clk6x) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_acc.ovf) begin
        r_ovf <= 1'b1;
      end else if (err_clr_i) begin
        r_ovf <= 1'b0;
      end
      if (w_acc.unf) begin
        r_unf <= 1'b1;
      end else if (err_clr_i) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign ovf_o = r_ovf;
  assign unf_o = r_unf;
`else
  logic w_unused_err;

  assign w_unused_err = ^{err_clr_i, w_acc.ovf, w_acc.unf};
  assign ovf_o        = 1'b0;
  assign unf_o        = 1'b0;
`endif

  assign full_o   = r_full;
  assign empty_o  = r_empty;
  assign afull_o  = r_afull;
  assign aempty_o = r_aempty;
  assign level_o  = r_level;

endmodule
